// File: rtl/axis_rx_pkg.sv
// Shared definitions for the RX ingress arbiter.
//   DATA_W_DEF / KEEP_W_DEF : default datapath widths
//   MAX_IN / PTR_W          : largest supported source count and its index width
//   arb_state_t             : arbiter FSM state encoding
//   rr_pick()               : round-robin search over a request vector
package axis_rx_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int KEEP_W_DEF = DATA_W_DEF / 8;
   localparam int MAX_IN     = 8;
   localparam int PTR_W      = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // First set bit of req[0..n-1] scanning ptr, ptr+1, ... modulo n.
   // Returns 0 when nothing is requesting; callers only use it with req != 0.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_IN-1:0] req,
                                                input logic [PTR_W-1:0]  ptr,
                                                input int unsigned       n);
      logic [PTR_W-1:0] pick;
      logic [PTR_W-1:0] idx;
      logic             found;
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_IN; i++) begin
         idx = PTR_W'((32'(ptr) + i) % n);
         if (!found && (i < n) && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/axis_rx_arbiter_skid.sv
// Two-entry skid buffer for an AXI-Stream style boundary.
// Output register plus one overflow register; both data and ready are
// registered so no combinational path runs from m_ready back to s_ready.
//   aclk, aresetn  : clock, async active-low reset
//   s_data/s_valid : upstream beat;  s_ready : registered space-available
//   m_data/m_valid : registered downstream beat;  m_ready : downstream accept
module axis_skid_buf #(
   parameter int WIDTH = 8
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready
);

   logic [WIDTH-1:0] skid_data_q, skid_data_d, out_data_d;
   logic             skid_valid_q, skid_valid_d, out_valid_d;
   logic             push;

   assign push = s_valid & s_ready;

   always_comb begin
      out_valid_d  = m_valid;
      out_data_d   = m_data;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (skid_valid_q) begin
         // full: s_ready is low, so only the drain side can move
         if (m_ready) begin
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end
      end else if (!m_valid || m_ready) begin
         out_valid_d = push;
         if (push) out_data_d = s_data;
      end else if (push) begin
         skid_valid_d = 1'b1;
         skid_data_d  = s_data;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_valid      <= 1'b0;
         m_data       <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         s_ready      <= 1'b1;
      end else begin
         m_valid      <= out_valid_d;
         m_data       <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         s_ready      <= ~skid_valid_d;
      end
   end

endmodule

// File: rtl/axis_rx_arbiter.sv
// Packet-atomic round-robin merge of NUM_IN AXI-Stream sources onto one
// registered RX stream. One whole frame (through tlast) per grant.
//   aclk, aresetn                      : clock, async active-low reset
//   s_tdata/s_tkeep/s_tlast/s_tvalid   : packed ingress streams, source i at slice i
//   s_tready                           : ingress ready, only the granted bit can be high
//   m_tdata/m_tkeep/m_tlast/m_tid      : merged registered egress beat and its source index
//   m_tvalid/m_tready                  : egress handshake
//   cfg_en                             : per-source enable, sampled at arbitration only
//   frame_done                         : one-cycle pulse per source on tlast acceptance
//
// state | meaning
// IDLE  | no grant held; pick next requester round-robin from rr_ptr
// BUSY  | grant held; forward beats of the granted source until tlast
module axis_rx_arbiter
   import axis_rx_pkg::*;
#(
   parameter int NUM_IN = 4,
   parameter int DATA_W = DATA_W_DEF,
   parameter int KEEP_W = DATA_W / 8,
   parameter int ID_W   = $clog2(NUM_IN)
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [NUM_IN*DATA_W-1:0] s_tdata,
   input  logic [NUM_IN*KEEP_W-1:0] s_tkeep,
   input  logic [NUM_IN-1:0]        s_tlast,
   input  logic [NUM_IN-1:0]        s_tvalid,
   output logic [NUM_IN-1:0]        s_tready,
   output logic [DATA_W-1:0]        m_tdata,
   output logic [KEEP_W-1:0]        m_tkeep,
   output logic                     m_tlast,
   output logic [ID_W-1:0]          m_tid,
   output logic                     m_tvalid,
   input  logic                     m_tready,
   input  logic [NUM_IN-1:0]        cfg_en,
   output logic [NUM_IN-1:0]        frame_done
);

   localparam int PAY_W = DATA_W + KEEP_W + 1 + ID_W;

   arb_state_t        state_q, state_d;
   logic [ID_W-1:0]   grant_q, grant_d, rr_ptr_q, rr_ptr_d;
   logic [NUM_IN-1:0] frame_done_d;
   logic [NUM_IN-1:0] req;
   logic [MAX_IN-1:0] req_ext;
   logic              sel_valid, sel_last, skid_in_ready, accept;
   logic [DATA_W-1:0] sel_data;
   logic [KEEP_W-1:0] sel_keep;
   logic [PAY_W-1:0]  skid_out;

   assign req = s_tvalid & cfg_en;

   always_comb begin
      req_ext             = '0;
      req_ext[NUM_IN-1:0] = req;
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      sel_keep  = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant_q == ID_W'(i)) begin
            sel_valid = s_tvalid[i];
            sel_last  = s_tlast[i];
            sel_data  = s_tdata[i*DATA_W +: DATA_W];
            sel_keep  = s_tkeep[i*KEEP_W +: KEEP_W];
         end
      end
   end

   assign accept = (state_q == BUSY) & sel_valid & skid_in_ready;

   always_comb begin
      s_tready = '0;
      if (state_q == BUSY) s_tready[grant_q] = skid_in_ready;
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rr_ptr_d     = rr_ptr_q;
      frame_done_d = '0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d = ID_W'(rr_pick(req_ext, PTR_W'(rr_ptr_q), NUM_IN));
               state_d = BUSY;
            end
         end
         BUSY: begin
            // cfg_en is not consulted here: a disabled source still finishes its frame
            if (accept && sel_last) begin
               frame_done_d[grant_q] = 1'b1;
               rr_ptr_d = (grant_q == ID_W'(NUM_IN - 1)) ? '0 : grant_q + ID_W'(1);
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         frame_done <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         frame_done <= frame_done_d;
      end
   end

   axis_skid_buf #(.WIDTH(PAY_W)) u_skid (
      .aclk    (aclk),
      .aresetn (aresetn),
      .s_data  ({sel_last, grant_q, sel_keep, sel_data}),
      .s_valid (accept),
      .s_ready (skid_in_ready),
      .m_data  (skid_out),
      .m_valid (m_tvalid),
      .m_ready (m_tready)
   );

   assign {m_tlast, m_tid, m_tkeep, m_tdata} = skid_out;

endmodule

// File: tb/tb_axis_rx_arbiter.sv
// Self-checking bench for axis_rx_arbiter: directed scenarios plus random
// frames, all checked against a frame-level round-robin reference model.
module tb_axis_rx_arbiter;

   localparam int NUM_IN = 4;
   localparam int DATA_W = 64;
   localparam int KEEP_W = 8;
   localparam int ID_W   = 2;
   localparam int PK_W   = DATA_W + KEEP_W + ID_W + 2;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [KEEP_W-1:0] keep;
      logic              last;
      logic [ID_W-1:0]   id;
   } beat_t;

   logic                     aclk, aresetn;
   logic [NUM_IN*DATA_W-1:0] s_tdata;
   logic [NUM_IN*KEEP_W-1:0] s_tkeep;
   logic [NUM_IN-1:0]        s_tlast, s_tvalid, s_tready, cfg_en, frame_done;
   logic [DATA_W-1:0]        m_tdata;
   logic [KEEP_W-1:0]        m_tkeep;
   logic                     m_tlast, m_tvalid, m_tready;
   logic [ID_W-1:0]          m_tid;

   axis_rx_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
      .s_tvalid(s_tvalid), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid),
      .m_tvalid(m_tvalid), .m_tready(m_tready),
      .cfg_en(cfg_en), .frame_done(frame_done)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   beat_t             src_q [NUM_IN][$];
   beat_t             exp_q [$];
   int                got_tid [$];
   int                fd_order [$];
   int                fd_cnt [NUM_IN];
   int                exp_fd [NUM_IN];
   int                n_chk = 0, n_err = 0, cyc = 0, model_ptr = 0, occ = 0, mv_first = -1;
   bit                gap_en = 1'b0, rdy_rand = 1'b0, prev_stall = 1'b0;
   logic              rdy_next = 1'b1;
   logic [NUM_IN-1:0] forbid = '0, sof = '1;
   logic [PK_W-1:0]   prev_pack = '0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // One clock: observe at the falling edge, then drive just after the rising edge.
   task automatic tick();
      logic [NUM_IN-1:0] acc;
      logic [PK_W-1:0]   pack;
      beat_t             e, b;
      @(negedge aclk);
      acc  = s_tvalid & s_tready;
      pack = {m_tvalid, m_tlast, m_tid, m_tkeep, m_tdata};
      chk("tready_onehot", 128'($countones(s_tready) <= 1), 128'(1));
      chk("tready_forbid", 128'(s_tready & forbid), 128'(0));
      if (occ >= 2) chk("tready_full", 128'(s_tready), 128'(0));
      if (prev_stall) chk("hold", 128'(pack), 128'(prev_pack));
      prev_stall = m_tvalid & ~m_tready;
      prev_pack  = pack;
      if (m_tvalid && mv_first < 0) mv_first = cyc;
      if (m_tvalid && m_tready) begin
         if (exp_q.size() == 0) chk("extra_beat", 128'(pack), 128'(0));
         else begin
            e = exp_q.pop_front();
            chk("m_tdata", 128'(m_tdata), 128'(e.data));
            chk("m_side", 128'({m_tlast, m_tid, m_tkeep}), 128'({e.last, e.id, e.keep}));
         end
         if (m_tlast) got_tid.push_back(int'(m_tid));
      end
      occ = occ + $countones(acc) - ((m_tvalid && m_tready) ? 1 : 0);
      chk("occupancy", 128'(occ <= 2), 128'(1));
      for (int i = 0; i < NUM_IN; i++)
         if (frame_done[i]) begin
            fd_cnt[i]++;
            fd_order.push_back(i);
         end
      @(posedge aclk);
      cyc++;
      #1;
      for (int i = 0; i < NUM_IN; i++) begin
         if (acc[i] && src_q[i].size() > 0) begin
            b      = src_q[i].pop_front();
            sof[i] = b.last;
         end
         if (src_q[i].size() == 0) s_tvalid[i] = 1'b0;
         else if (!(s_tvalid[i] && !acc[i]))
            s_tvalid[i] = sof[i] | ~gap_en | ($urandom_range(0, 2) != 0);
         if (src_q[i].size() > 0) begin
            b = src_q[i][0];
            s_tdata[i*DATA_W +: DATA_W] = b.data;
            s_tkeep[i*KEEP_W +: KEEP_W] = b.keep;
            s_tlast[i]                  = b.last;
         end
      end
      m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_next;
   endtask

   task automatic do_reset(input int hold);
      aresetn = 1'b0;
      #1;
      chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
      chk("rst_s_tready", 128'(s_tready), 128'(0));
      chk("rst_outputs", 128'({m_tdata, m_tkeep, m_tlast, m_tid, frame_done}), 128'(0));
      for (int i = 0; i < NUM_IN; i++) begin
         src_q[i].delete();
         fd_cnt[i] = 0;
         exp_fd[i] = 0;
      end
      exp_q.delete();
      got_tid.delete();
      fd_order.delete();
      s_tvalid   = '0;
      sof        = '1;
      occ        = 0;
      prev_stall = 1'b0;
      model_ptr  = 0;
      forbid     = '0;
      repeat (hold) tick();
      aresetn = 1'b1;
   endtask

   task automatic add_beat(input int src, input logic [DATA_W-1:0] d,
                           input logic [KEEP_W-1:0] k, input logic l);
      beat_t b;
      b.data = d; b.keep = k; b.last = l; b.id = '0;
      src_q[src].push_back(b);
   endtask

   task automatic add_frame(input int src, input int len);
      for (int k = 0; k < len; k++)
         add_beat(src, {$urandom(), $urandom()}, KEEP_W'($urandom()), k == len - 1);
   endtask

   // Reference: every loaded source requests at each arbitration; whole frames
   // are taken in round-robin order starting after the last served source.
   task automatic build_expected();
      int    pos [NUM_IN];
      int    c, j;
      bit    found;
      beat_t b;
      foreach (pos[i]) pos[i] = 0;
      forever begin
         found = 1'b0;
         c     = 0;
         for (int k = 0; k < NUM_IN; k++) begin
            j = (model_ptr + k) % NUM_IN;
            if (!found && cfg_en[j] && pos[j] < src_q[j].size()) begin
               found = 1'b1;
               c     = j;
            end
         end
         if (!found) break;
         do begin
            b    = src_q[c][pos[c]];
            b.id = ID_W'(c);
            pos[c]++;
            exp_q.push_back(b);
         end while (!b.last);
         exp_fd[c]++;
         model_ptr = (c + 1) % NUM_IN;
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain_timeout", 128'(exp_q.size()), 128'(0));
      repeat (4) tick();
   endtask

   task automatic chk_fd();
      for (int i = 0; i < NUM_IN; i++) chk("frame_done_cnt", 128'(fd_cnt[i]), 128'(exp_fd[i]));
   endtask

   task automatic wait_size(input int src, input int sz, input int budget);
      int n = 0;
      while (src_q[src].size() > sz && n < budget) begin
         tick();
         n++;
      end
      chk("wait_timeout", 128'(src_q[src].size() <= sz), 128'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int sv;
      aresetn  = 1'b1;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = '0;
      s_tvalid = '0;
      m_tready = 1'b1;
      cfg_en   = '1;
      #3;
      do_reset(3);

      // single frame on port 0, directed data
      add_beat(0, 64'hABCDEF10ABCDEF10, 8'hFF, 1'b0);
      add_beat(0, 64'h4353456346346343, 8'hFF, 1'b0);
      add_beat(0, 64'h4378654876545566, 8'hFF, 1'b0);
      add_beat(0, 64'h123456789ABCDEF0, 8'hFF, 1'b1);
      build_expected();
      mv_first = -1;
      tick();
      sv = cyc;
      drain(100);
      chk("first_latency", 128'(mv_first - sv), 128'(2));
      chk_fd();

      // ports 0 and 2 simultaneously after reset
      do_reset(2);
      add_frame(0, 3);
      add_frame(2, 3);
      build_expected();
      drain(200);
      chk("fd_order_n", 128'(fd_order.size()), 128'(2));
      for (int k = 0; k < fd_order.size() && k < 2; k++)
         chk("fd_order", 128'(fd_order[k]), 128'(k * 2));
      chk_fd();

      // all ports streaming 2-beat frames
      do_reset(2);
      for (int f = 0; f < 2; f++)
         for (int s = 0; s < NUM_IN; s++) add_frame(s, 2);
      build_expected();
      drain(400);
      chk("grant_n", 128'(got_tid.size()), 128'(8));
      foreach (got_tid[k]) chk("grant_order", 128'(got_tid[k]), 128'(k % NUM_IN));
      chk_fd();

      // egress stall then toggling ready
      do_reset(2);
      add_frame(1, 10);
      build_expected();
      for (int n = 0; n < 50 && exp_q.size() > 7; n++) tick();
      rdy_next = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("stall_tready", 128'(s_tready), 128'(0));
      for (int k = 0; k < 12; k++) begin
         rdy_next = (k % 2 == 0);
         tick();
      end
      rdy_next = 1'b1;
      drain(100);
      chk_fd();

      // masked source never served
      do_reset(2);
      cfg_en = 4'b1101;
      forbid = 4'b0010;
      add_frame(1, 3);
      add_frame(0, 2);
      add_frame(2, 2);
      build_expected();
      drain(200);
      chk("p1_pending", 128'(src_q[1].size()), 128'(3));
      forbid = '0;
      cfg_en = '1;
      build_expected();
      drain(100);

      // disabling the granted source mid-frame
      add_frame(0, 4);
      build_expected();
      add_frame(0, 4);
      wait_size(0, 7, 50);
      cfg_en[0] = 1'b0;
      drain(100);
      repeat (10) tick();
      chk("p0_regrant", 128'(src_q[0].size()), 128'(4));
      cfg_en = '1;
      build_expected();
      drain(100);
      chk_fd();

      // random frames, ingress gaps and egress back-pressure
      gap_en   = 1'b1;
      rdy_rand = 1'b1;
      for (int r = 0; r < 4; r++) begin
         for (int s = 0; s < NUM_IN; s++) begin
            int nf;
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) add_frame(s, $urandom_range(1, 5));
         end
         build_expected();
         drain(2000);
      end
      gap_en   = 1'b0;
      rdy_rand = 1'b0;
      rdy_next = 1'b1;
      chk_fd();

      // reset during beat 3 of a port 3 frame
      add_frame(3, 4);
      build_expected();
      wait_size(3, 2, 50);
      do_reset(3);
      add_frame(0, 2);
      add_frame(3, 2);
      build_expected();
      drain(200);
      chk("post_rst_n", 128'(got_tid.size()), 128'(2));
      if (got_tid.size() > 0) chk("post_rst_first", 128'(got_tid[0]), 128'(0));
      chk_fd();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
